fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_len_decode.sv | 26 ++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared states, length codes and defaults for the fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    localparam logic [7:0] HALT_OPCODE_DEFAULT = 8'hFF;

endpackage

// File: rtl/fetch_len_decode.sv
// rtl/fetch_len_decode.sv - opcode length decode and top-of-memory crossing check
module fetch_len_decode
    import fetch_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic [5:0] pc,
    output logic [1:0] len,
    output logic       crosses_top
);

    // Only the two length bits matter here; the rest of the opcode belongs to the decoder.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^opcode[5:0];

    always_comb begin
        case (opcode[7:6])
            2'b00:   len = LEN_1;
            2'b01:   len = LEN_2;
            default: len = LEN_3;
        endcase
    end

    // Widened by one bit so an instruction ending exactly at address 63 is still legal.
    assign crosses_top = ({1'b0, pc} + {5'd0, len}) > 7'd64;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with decoder handshake, redirect and halt
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [5:0] RESET_PC    = 6'd0,
    parameter logic [7:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    output logic [5:0] Addr,
    output logic       we,
    output logic [7:0] Data,
    input  logic [7:0] Opcode,
    input  logic [7:0] Operando1,
    input  logic [7:0] Operando2,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_op1,
    output logic [7:0] instr_op2,
    output logic [1:0] instr_len,
    output logic [5:0] instr_pc,
    input  logic       jump_valid,
    input  logic [5:0] jump_addr,
    output logic       halted,
    output logic       fault
);

    state_t     state, state_next;
    logic [5:0] pc, pc_next;
    logic       halt_pending, halt_pending_next;
    logic       valid_next, halted_next, fault_next;
    logic [7:0] opcode_next, op1_next, op2_next;
    logic [1:0] len_next;
    logic [5:0] ipc_next;

    logic [1:0] dec_len;
    logic       dec_crosses;

    fetch_len_decode u_len_decode (
        .opcode      (Opcode),
        .pc          (pc),
        .len         (dec_len),
        .crosses_top (dec_crosses)
    );

    assign Addr = pc;
    assign we   = 1'b0;
    assign Data = 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            halt_pending <= 1'b0;
            instr_valid  <= 1'b0;
            instr_opcode <= 8'h00;
            instr_op1    <= 8'h00;
            instr_op2    <= 8'h00;
            instr_len    <= 2'd0;
            instr_pc     <= 6'd0;
            halted       <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            halt_pending <= halt_pending_next;
            instr_valid  <= valid_next;
            instr_opcode <= opcode_next;
            instr_op1    <= op1_next;
            instr_op2    <= op2_next;
            instr_len    <= len_next;
            instr_pc     <= ipc_next;
            halted       <= halted_next;
            fault        <= fault_next;
        end
    end

    always_comb begin
        state_next        = state;
        pc_next           = pc;
        halt_pending_next = halt_pending;
        valid_next        = instr_valid;
        opcode_next       = instr_opcode;
        op1_next          = instr_op1;
        op2_next          = instr_op2;
        len_next          = instr_len;
        ipc_next          = instr_pc;
        halted_next       = halted;
        fault_next        = fault;

        case (state)
            FETCH: begin
                if (jump_valid) begin
                    pc_next    = jump_addr;
                    valid_next = 1'b0;
                end else begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                if (jump_valid) begin
                    pc_next    = jump_addr;
                    valid_next = 1'b0;
                    state_next = FETCH;
                end else if (dec_crosses) begin
                    fault_next  = 1'b1;
                    halted_next = 1'b1;
                    state_next  = HALT;
                end else begin
                    opcode_next       = Opcode;
                    op1_next          = (dec_len >= LEN_2) ? Operando1 : 8'h00;
                    op2_next          = (dec_len == LEN_3) ? Operando2 : 8'h00;
                    len_next          = dec_len;
                    ipc_next          = pc;
                    valid_next        = 1'b1;
                    halt_pending_next = (Opcode == HALT_OPCODE);
                    state_next        = HOLD;
                end
            end

            HOLD: begin
                if (jump_valid) begin
                    pc_next           = jump_addr;
                    valid_next        = 1'b0;
                    halt_pending_next = 1'b0;
                    state_next        = FETCH;
                end else if (instr_ready) begin
                    valid_next = 1'b0;
                    if (halt_pending) begin
                        // The halt instruction has been handed over; pc stays on it.
                        halt_pending_next = 1'b0;
                        halted_next       = 1'b1;
                        state_next        = HALT;
                    end else begin
                        pc_next    = instr_pc + {4'd0, instr_len};
                        state_next = FETCH;
                    end
                end
            end

            default: begin
                state_next = HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Addr;
    logic       we;
    logic [7:0] Data;
    logic [7:0] Opcode, Operando1, Operando2;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic [7:0] instr_opcode, instr_op1, instr_op2;
    logic [1:0] instr_len;
    logic [5:0] instr_pc;
    logic       jump_valid = 1'b0;
    logic [5:0] jump_addr = 6'd0;
    logic       halted, fault;

    logic [7:0] mem [64];
    logic [5:0] addr_p1, addr_p2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .Addr         (Addr),
        .we           (we),
        .Data         (Data),
        .Opcode       (Opcode),
        .Operando1    (Operando1),
        .Operando2    (Operando2),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_op1    (instr_op1),
        .instr_op2    (instr_op2),
        .instr_len    (instr_len),
        .instr_pc     (instr_pc),
        .jump_valid   (jump_valid),
        .jump_addr    (jump_addr),
        .halted       (halted),
        .fault        (fault)
    );

    // Synchronous-read RAM: data for Addr appears one edge later.
    assign addr_p1 = Addr + 6'd1;
    assign addr_p2 = Addr + 6'd2;
    always @(posedge clk) begin
        Opcode    <= mem[Addr];
        Operando1 <= mem[addr_p1];
        Operando2 <= mem[addr_p2];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        jump_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("valid_seen", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic check_instr(input string tag, input logic [5:0] pc, input logic [1:0] len,
                               input logic [7:0] op, input logic [7:0] o1, input logic [7:0] o2);
        check_eq({tag, "_pc"},  {26'd0, instr_pc},     {26'd0, pc});
        check_eq({tag, "_len"}, {30'd0, instr_len},    {30'd0, len});
        check_eq({tag, "_opc"}, {24'd0, instr_opcode}, {24'd0, op});
        check_eq({tag, "_op1"}, {24'd0, instr_op1},    {24'd0, o1});
        check_eq({tag, "_op2"}, {24'd0, instr_op2},    {24'd0, o2});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"},  {31'd0, instr_valid},  32'd0);
        check_eq({tag, "_opc"},    {24'd0, instr_opcode}, 32'd0);
        check_eq({tag, "_op1"},    {24'd0, instr_op1},    32'd0);
        check_eq({tag, "_op2"},    {24'd0, instr_op2},    32'd0);
        check_eq({tag, "_len"},    {30'd0, instr_len},    32'd0);
        check_eq({tag, "_ipc"},    {26'd0, instr_pc},     32'd0);
        check_eq({tag, "_halted"}, {31'd0, halted},       32'd0);
        check_eq({tag, "_fault"},  {31'd0, fault},        32'd0);
        check_eq({tag, "_addr"},   {26'd0, Addr},         32'd0);
        check_eq({tag, "_we"},     {31'd0, we},           32'd0);
        check_eq({tag, "_data"},   {24'd0, Data},         32'd0);
    endtask

    initial begin
        int n;
        int vcount;

        clear_mem();
        tick();
        check_reset_outputs("por");

        // Straight-line fetch with ready held high
        mem[0] = 8'h05;
        mem[1] = 8'h45; mem[2] = 8'h10;
        mem[3] = 8'h85; mem[4] = 8'h20; mem[5] = 8'h30;
        do_reset();
        instr_ready = 1'b1;
        wait_valid(n);
        check_eq("lat_first", n, 32'd2);
        check_instr("s1_i0", 6'd0, 2'd1, 8'h05, 8'h00, 8'h00);
        tick();
        wait_valid(n);
        check_eq("gap_b2b", n + 1, 32'd3);
        check_instr("s1_i1", 6'd1, 2'd2, 8'h45, 8'h10, 8'h00);
        tick();
        wait_valid(n);
        check_instr("s1_i2", 6'd3, 2'd3, 8'h85, 8'h20, 8'h30);
        tick();
        check_eq("s1_next_addr", {26'd0, Addr}, 32'd6);

        // Back-pressure on the instruction at address 1
        do_reset();
        instr_ready = 1'b1;
        wait_valid(n);
        check_eq("bp_first_pc", {26'd0, instr_pc}, 32'd0);
        tick();
        instr_ready = 1'b0;
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("bp_ipc",   {26'd0, instr_pc},    32'd1);
            check_eq("bp_opc",   {24'd0, instr_opcode}, 32'h45);
            check_eq("bp_op1",   {24'd0, instr_op1},   32'h10);
            check_eq("bp_addr",  {26'd0, Addr},        32'd1);
        end
        instr_ready = 1'b1;
        tick();
        wait_valid(n);
        check_eq("bp_after_pc", {26'd0, instr_pc}, 32'd3);

        // Redirect coinciding with a handshake
        mem[20] = 8'h41; mem[21] = 8'h77;
        do_reset();
        instr_ready = 1'b1;
        wait_valid(n);
        jump_valid = 1'b1;
        jump_addr  = 6'd20;
        tick();
        jump_valid = 1'b0;
        check_eq("jmp_addr",  {26'd0, Addr},        32'd20);
        check_eq("jmp_valid", {31'd0, instr_valid}, 32'd0);
        wait_valid(n);
        check_instr("jmp_i", 6'd20, 2'd2, 8'h41, 8'h77, 8'h00);

        // Halt opcode at address 4
        clear_mem();
        mem[0] = 8'h05;
        mem[1] = 8'h45; mem[2] = 8'h10;
        mem[3] = 8'h05;
        mem[4] = 8'hFF; mem[5] = 8'h11; mem[6] = 8'h22;
        do_reset();
        instr_ready = 1'b1;
        wait_valid(n); tick();
        wait_valid(n); tick();
        wait_valid(n); tick();
        wait_valid(n);
        check_instr("halt_i", 6'd4, 2'd3, 8'hFF, 8'h11, 8'h22);
        tick();
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (instr_valid) vcount++;
            tick();
        end
        check_eq("halt_once",   vcount, 32'd0);
        check_eq("halt_halted", {31'd0, halted}, 32'd1);
        check_eq("halt_addr",   {26'd0, Addr},   32'd4);
        jump_valid = 1'b1;
        jump_addr  = 6'd20;
        tick();
        jump_valid = 1'b0;
        tick();
        check_eq("halt_jmp_addr",  {26'd0, Addr},        32'd4);
        check_eq("halt_jmp_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("halt_fault",     {31'd0, fault},       32'd0);

        // Instruction crossing the top of memory
        clear_mem();
        mem[62] = 8'h80;
        mem[63] = 8'h05;
        do_reset();
        instr_ready = 1'b1;
        jump_valid  = 1'b1;
        jump_addr   = 6'd62;
        tick();
        jump_valid = 1'b0;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (instr_valid) vcount++;
            tick();
        end
        check_eq("bnd_valid",  vcount, 32'd0);
        check_eq("bnd_fault",  {31'd0, fault},  32'd1);
        check_eq("bnd_halted", {31'd0, halted}, 32'd1);

        do_reset();
        jump_valid = 1'b1;
        jump_addr  = 6'd63;
        tick();
        jump_valid = 1'b0;
        wait_valid(n);
        check_instr("wrap_i", 6'd63, 2'd1, 8'h05, 8'h00, 8'h00);
        tick();
        check_eq("wrap_addr",  {26'd0, Addr},  32'd0);
        check_eq("wrap_fault", {31'd0, fault}, 32'd0);

        // Reset while an instruction is pending
        mem[20] = 8'h41; mem[21] = 8'h77;
        do_reset();
        instr_ready = 1'b0;
        jump_valid  = 1'b1;
        jump_addr   = 6'd20;
        tick();
        jump_valid = 1'b0;
        wait_valid(n);
        check_eq("rh_addr_pre", {26'd0, Addr}, 32'd20);
        rst         = 1'b1;
        instr_ready = 1'b1;
        tick();
        check_reset_outputs("rh");
        rst = 1'b0;
        tick();
        check_eq("rh_addr_post", {26'd0, Addr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
